// File: rtl/nn_argmax.sv
// Serial argmax over the ten output-layer scores of the NN accelerator.
// Optional runner-up/margin outputs are enabled with `define ARGMAX_TOP2_EN.
module nn_argmax #(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [DATA_W-1:0] result0,
  input  logic [DATA_W-1:0] result1,
  input  logic [DATA_W-1:0] result2,
  input  logic [DATA_W-1:0] result3,
  input  logic [DATA_W-1:0] result4,
  input  logic [DATA_W-1:0] result5,
  input  logic [DATA_W-1:0] result6,
  input  logic [DATA_W-1:0] result7,
  input  logic [DATA_W-1:0] result8,
  input  logic [DATA_W-1:0] result9,
  input  logic              out_ack,
  output logic [3:0]        class_idx,
  output logic [DATA_W-1:0] class_val,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [3:0]        second_idx,
  output logic [DATA_W-1:0] second_val,
  output logic [DATA_W:0]   margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  state_e            state_q, state_d;
  logic              ready_q;
  logic              start;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [3:0]        best_idx_q, best_idx_d;
  logic [3:0]        class_idx_q, class_idx_d;
  logic [DATA_W-1:0] class_val_q, class_val_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              cap_en;
  logic [DATA_W-1:0] cur_val;
  logic [DATA_W-1:0] res_in [10];
  logic [DATA_W-1:0] buf_q  [10];

`ifdef ARGMAX_TOP2_EN
  logic              sec_vld_q, sec_vld_d;
  logic [3:0]        sec_idx_q, sec_idx_d;
  logic [DATA_W-1:0] sec_val_q, sec_val_d;
  logic [3:0]        second_idx_q, second_idx_d;
  logic [DATA_W-1:0] second_val_q, second_val_d;
  logic [DATA_W:0]   best_ext, sec_ext;
`endif

  assign res_in[0] = result0;
  assign res_in[1] = result1;
  assign res_in[2] = result2;
  assign res_in[3] = result3;
  assign res_in[4] = result4;
  assign res_in[5] = result5;
  assign res_in[6] = result6;
  assign res_in[7] = result7;
  assign res_in[8] = result8;
  assign res_in[9] = result9;

  // ready_q resets high so a ready already asserted at reset release is not an edge.
  assign start   = ready & ~ready_q;
  assign cur_val = buf_q[idx_q];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    class_val_d = class_val_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q | (start & (state_q != IDLE));
    cap_en      = 1'b0;
`ifdef ARGMAX_TOP2_EN
    sec_vld_d    = sec_vld_q;
    sec_idx_d    = sec_idx_q;
    sec_val_d    = sec_val_q;
    second_idx_d = second_idx_q;
    second_val_d = second_val_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_en     = 1'b1;
          best_val_d = result0;
          best_idx_d = 4'd0;
          idx_d      = 4'd1;
          state_d    = SCAN;
`ifdef ARGMAX_TOP2_EN
          sec_vld_d  = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (gt(cur_val, best_val_q)) begin
          best_val_d = cur_val;
          best_idx_d = idx_q;
`ifdef ARGMAX_TOP2_EN
          sec_vld_d  = 1'b1;
          sec_idx_d  = best_idx_q;
          sec_val_d  = best_val_q;
`endif
        end
`ifdef ARGMAX_TOP2_EN
        else if (!sec_vld_q || gt(cur_val, sec_val_q)) begin
          sec_vld_d = 1'b1;
          sec_idx_d = idx_q;
          sec_val_d = cur_val;
        end
`endif
        idx_d = idx_q + 4'd1;
        // Entry 9 is folded in combinationally so results land on this same edge.
        if (idx_q == 4'd9) begin
          class_idx_d = best_idx_d;
          class_val_d = best_val_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef ARGMAX_TOP2_EN
          second_idx_d = sec_idx_d;
          second_val_d = sec_val_d;
`endif
        end
      end
      DONE: begin
        if (out_ack) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      idx_q       <= 4'd0;
      best_val_q  <= '0;
      best_idx_q  <= 4'd0;
      class_idx_q <= 4'd0;
      class_val_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ARGMAX_TOP2_EN
      sec_vld_q    <= 1'b0;
      sec_idx_q    <= 4'd0;
      sec_val_q    <= '0;
      second_idx_q <= 4'd0;
      second_val_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready;
      idx_q       <= idx_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      class_val_q <= class_val_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef ARGMAX_TOP2_EN
      sec_vld_q    <= sec_vld_d;
      sec_idx_q    <= sec_idx_d;
      sec_val_q    <= sec_val_d;
      second_idx_q <= second_idx_d;
      second_val_q <= second_val_d;
`endif
    end
  end

  // Snapshot buffer: data only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int i = 0; i < 10; i++) buf_q[i] <= res_in[i];
    end
  end

  assign class_idx = class_idx_q;
  assign class_val = class_val_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

`ifdef ARGMAX_TOP2_EN
  // One extra bit keeps best - second non-negative in both compare modes.
  assign best_ext   = {(SIGNED ? class_val_q[DATA_W-1] : 1'b0), class_val_q};
  assign sec_ext    = {(SIGNED ? second_val_q[DATA_W-1] : 1'b0), second_val_q};
  assign second_idx = second_idx_q;
  assign second_val = second_val_q;
  assign margin     = best_ext - sec_ext;
`endif

endmodule

// File: tb/tb_nn_argmax.sv
// Directed bench for nn_argmax: a signed and an unsigned instance share one stimulus.
module tb_nn_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        out_ack;
  logic [31:0] res [10];

  logic [3:0]  class_idx, u_class_idx;
  logic [31:0] class_val, u_class_val;
  logic        out_valid, u_out_valid;
  logic        busy, u_busy;
  logic        overrun, u_overrun;
`ifdef ARGMAX_TOP2_EN
  logic [3:0]  second_idx, u_second_idx;
  logic [31:0] second_val, u_second_val;
  logic [32:0] margin, u_margin;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nn_argmax #(.DATA_W(32), .SIGNED(1'b1)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3]), .result4(res[4]),
    .result5(res[5]), .result6(res[6]), .result7(res[7]), .result8(res[8]), .result9(res[9]),
    .out_ack(out_ack), .class_idx(class_idx), .class_val(class_val),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
`ifdef ARGMAX_TOP2_EN
    , .second_idx(second_idx), .second_val(second_val), .margin(margin)
`endif
  );

  nn_argmax #(.DATA_W(32), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .ready(ready),
    .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3]), .result4(res[4]),
    .result5(res[5]), .result6(res[6]), .result7(res[7]), .result8(res[8]), .result9(res[9]),
    .out_ack(out_ack), .class_idx(u_class_idx), .class_val(u_class_val),
    .out_valid(u_out_valid), .busy(u_busy), .overrun(u_overrun)
`ifdef ARGMAX_TOP2_EN
    , .second_idx(u_second_idx), .second_val(u_second_val), .margin(u_margin)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 10; i++) res[i] = v;
  endtask

  // Fresh ready edge, capture, then count edges until out_valid (expect 9).
  task automatic classify(input string tag, input bit corrupt);
    int cyc;
    ready = 1'b0;
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    if (corrupt) set_all(32'h7FFF_FFFF);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd9);
  endtask

  task automatic ack(input string tag);
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    check({tag, "_ack_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ack_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit seen;
    reset   = 1'b1;
    ready   = 1'b1;
    out_ack = 1'b0;
    set_all(32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_idx", 64'(class_idx), 64'd0);
    check("rst_val", 64'(class_val), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_u_busy", 64'(u_busy), 64'd0);
`ifdef ARGMAX_TOP2_EN
    check("rst_margin", 64'(margin), 64'd0);
`endif

    // Basic: class 3 wins; inputs trashed after capture must not matter.
    set_all(32'd5); res[3] = 32'd100;
    classify("t1", 1'b1);
    check("t1_idx", 64'(class_idx), 64'd3);
    check("t1_val", 64'(class_val), 64'd100);
    ack("t1");

    // All negative: -2 wins in both modes (0xFFFFFFFE is also the largest unsigned).
    set_all(32'hFFFF_FC18); res[0] = 32'hFFFF_FFCE; res[7] = 32'hFFFF_FFFE;
    classify("t2", 1'b0);
    check("t2_s_idx", 64'(class_idx), 64'd7);
    check("t2_s_val", 64'(class_val), 64'hFFFF_FFFE);
    check("t2_u_idx", 64'(u_class_idx), 64'd7);
    ack("t2");

    // Mixed signs: signed picks +100, unsigned picks -50 (0xFFFFFFCE).
    set_all(32'hFFFF_FC18); res[0] = 32'hFFFF_FFCE; res[5] = 32'd100;
    classify("t3", 1'b0);
    check("t3_s_idx", 64'(class_idx), 64'd5);
    check("t3_u_idx", 64'(u_class_idx), 64'd0);
    check("t3_u_val", 64'(u_class_val), 64'hFFFF_FFCE);
    ack("t3");

    // Extremes: 0x7FFFFFFF is signed max, 0x80000000 beats it unsigned.
    set_all(32'd0); res[2] = 32'h8000_0000; res[8] = 32'h7FFF_FFFF;
    classify("t4", 1'b0);
    check("t4_s_idx", 64'(class_idx), 64'd8);
    check("t4_u_idx", 64'(u_class_idx), 64'd2);
    check("t4_u_val", 64'(u_class_val), 64'h8000_0000);
    ack("t4");

    // Tie keeps the lower index.
    set_all(32'd0); res[2] = 32'd42; res[6] = 32'd42;
    classify("t5", 1'b0);
    check("t5_idx", 64'(class_idx), 64'd2);
    check("t5_val", 64'(class_val), 64'd42);
    ack("t5");

    // Held DONE with an ignored ready edge.
    set_all(32'd0); res[1] = 32'd77;
    classify("t6", 1'b0);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("t6_hold_valid", 64'(out_valid), 64'd1);
    check("t6_hold_idx", 64'(class_idx), 64'd1);
    check("t6_hold_val", 64'(class_val), 64'd77);
    check("t6_overrun", 64'(overrun), 64'd1);
    ack("t6");
    set_all(32'd3); res[9] = 32'd500;
    classify("t7", 1'b0);
    check("t7_idx", 64'(class_idx), 64'd9);
    check("t7_val", 64'(class_val), 64'd500);
    check("t7_overrun", 64'(overrun), 64'd1);
    ack("t7");

    // Reset during the 4th SCAN cycle aborts with no result.
    set_all(32'd1); res[6] = 32'd66;
    ready = 1'b0;
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t8_rst_busy", 64'(busy), 64'd0);
    check("t8_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("t8_no_valid", 64'(seen), 64'd0);
    check("t8_overrun_clr", 64'(overrun), 64'd0);
    set_all(32'd1); res[4] = 32'd9;
    classify("t9", 1'b0);
    check("t9_idx", 64'(class_idx), 64'd4);
    check("t9_val", 64'(class_val), 64'd9);
    ack("t9");

`ifdef ARGMAX_TOP2_EN
    set_all(32'd0); res[0] = 32'd10; res[4] = 32'd30; res[9] = 32'd25;
    classify("t10", 1'b0);
    check("t10_idx", 64'(class_idx), 64'd4);
    check("t10_sec_idx", 64'(second_idx), 64'd9);
    check("t10_sec_val", 64'(second_val), 64'd25);
    check("t10_margin", 64'(margin), 64'd5);
    check("t10_u_margin", 64'(u_margin), 64'd5);
    ack("t10");
    set_all(32'd7);
    classify("t11", 1'b0);
    check("t11_idx", 64'(class_idx), 64'd0);
    check("t11_sec_idx", 64'(second_idx), 64'd1);
    check("t11_margin", 64'(margin), 64'd0);
    check("t11_u_sec_idx", 64'(u_second_idx), 64'd1);
    check("t11_u_sec_val", 64'(u_second_val), 64'd7);
    ack("t11");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
